run_sequencer: RTL and testbench

Initiator for the LED counter's go/done handshake. It debounces a start button, then launches a programmable number of back-to-back counter runs. For each run it drives the counter's active-low go line, watches the counter's LED value and done flag, and guards every phase with a watchdog. It sits between the board push-button and the counter, and reports progress and errors on its own status outputs.

---
 rtl/run_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_run_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer
//   Initiator for the LED counter's go/done handshake. A debounced press of
//   start_btn launches RUNS back-to-back counter runs. For each run the block
//   pulls go_n low, waits for the counter to start (cnt_led != 0), waits for
//   the rising edge of cnt_done, then waits for cnt_done to drop. Every phase
//   is guarded by a watchdog. A watchdog expiry parks the block in an error
//   state until the next press.
//
// Ports
//   clk          system clock (6 MHz), the only clock
//   rst_btn      synchronous reset, active-low
//   start_btn    active-low push-button, asynchronous to clk
//   cnt_led      counter LED value, from the counter's divided clock
//   cnt_done     counter done flag, active-high, from the divided clock
//   go_n         registered active-low go request to the counter
//   busy         high while arming, running or waiting for done to drop
//   run_count    runs completed since the last launch
//   all_done     one-cycle pulse once RUNS runs have completed
//   timeout_err  sticky watchdog error flag, cleared by the next press
module run_sequencer #(
  parameter logic [7:0]  RUNS            = 8'd3,
  parameter logic [27:0] TIMEOUT_CYCLES  = 28'd60_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd30_000
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       start_btn,
  input  logic [3:0] cnt_led,
  input  logic       cnt_done,
  output logic       go_n,
  output logic       busy,
  output logic [7:0] run_count,
  output logic       all_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // Two-flop synchronizers for every asynchronous input.
  logic [1:0] start_sync_reg;
  logic [3:0] led_s1_reg, led_s2_reg;
  logic       done_s1_reg, done_s2_reg, done_prev_reg;

  // Debounce.
  logic [15:0] db_cnt_reg;
  logic        start_lvl_reg, start_lvl_d_reg, start_pulse_reg;

  // Watchdog, run counter and registered outputs.
  logic [27:0] wd_cnt_reg;
  logic [7:0]  run_count_reg;
  logic        go_n_reg, busy_reg, all_done_reg, timeout_err_reg;

  logic done_rise, in_watch, next_watch, wd_hit;

  assign done_rise  = done_s2_reg & ~done_prev_reg;
  assign in_watch   = (state_reg == ST_ARM) || (state_reg == ST_RUN) || (state_reg == ST_GAP);
  assign next_watch = (state_next == ST_ARM) || (state_next == ST_RUN) || (state_next == ST_GAP);
  assign wd_hit     = (wd_cnt_reg == TIMEOUT_CYCLES - 28'd1);

  // The start synchronizer resets to the released level (1) so that leaving
  // reset never looks like a press edge to the debouncer.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      start_sync_reg <= 2'b11;
      led_s1_reg     <= 4'd0;
      led_s2_reg     <= 4'd0;
      done_s1_reg    <= 1'b0;
      done_s2_reg    <= 1'b0;
      done_prev_reg  <= 1'b0;
    end else begin
      start_sync_reg <= {start_sync_reg[0], start_btn};
      led_s1_reg     <= cnt_led;
      led_s2_reg     <= led_s1_reg;
      done_s1_reg    <= cnt_done;
      done_s2_reg    <= done_s1_reg;
      done_prev_reg  <= done_s2_reg;
    end
  end

  // The counter only advances while the synchronized level differs from the
  // accepted one; any return to the accepted level restarts it. The press
  // pulse is taken from the accepted level, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      db_cnt_reg      <= 16'd0;
      start_lvl_reg   <= 1'b1;
      start_lvl_d_reg <= 1'b1;
      start_pulse_reg <= 1'b0;
    end else begin
      if (start_sync_reg[1] != start_lvl_reg) begin
        if (db_cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
          start_lvl_reg <= start_sync_reg[1];
          db_cnt_reg    <= 16'd0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 16'd1;
        end
      end else begin
        db_cnt_reg <= 16'd0;
      end
      start_lvl_d_reg <= start_lvl_reg;
      start_pulse_reg <= start_lvl_d_reg & ~start_lvl_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start_pulse_reg) state_next = ST_ARM;
      ST_ARM:    if (led_s2_reg != 4'd0) state_next = ST_RUN;
      ST_RUN:    if (done_rise) state_next = ST_GAP;
      ST_GAP: begin
        if (!done_s2_reg) begin
          state_next = (run_count_reg == RUNS) ? ST_FINISH : ST_ARM;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      ST_ERR:    if (start_pulse_reg) state_next = ST_ARM;
      default:   state_next = ST_IDLE;
    endcase
    // Watchdog expiry wins over any handshake progress in the same cycle.
    if (in_watch && wd_hit) begin
      state_next = ST_ERR;
    end
  end

  // Watchdog restarts on every state change, so each phase gets a full budget.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      wd_cnt_reg <= 28'd0;
    end else if ((state_next != state_reg) || !in_watch) begin
      wd_cnt_reg <= 28'd0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 28'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state register.
  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      run_count_reg   <= 8'd0;
      go_n_reg        <= 1'b1;
      busy_reg        <= 1'b0;
      all_done_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_RUN) && (state_next == ST_GAP)) begin
        run_count_reg <= run_count_reg + 8'd1;
      end else if ((state_next == ST_ARM) &&
                   ((state_reg == ST_IDLE) || (state_reg == ST_ERR))) begin
        run_count_reg <= 8'd0;
      end
      go_n_reg        <= (state_next != ST_ARM);
      busy_reg        <= next_watch;
      all_done_reg    <= (state_next == ST_FINISH);
      timeout_err_reg <= (state_next == ST_ERR);
    end
  end

  assign go_n        = go_n_reg;
  assign busy        = busy_reg;
  assign run_count   = run_count_reg;
  assign all_done    = all_done_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//   Scoreboard bench for run_sequencer with RUNS=2, TIMEOUT_CYCLES=200,
//   DEBOUNCE_CYCLES=4. Each scenario pushes the hand-derived sequence of
//   output vectors {go_n, busy, all_done, timeout_err, run_count} it expects;
//   a monitor pops one entry each time the output vector changes.
module tb_run_sequencer;
  localparam logic [7:0]  RUNS_P = 8'd2;
  localparam logic [27:0] TMO_P  = 28'd200;
  localparam logic [15:0] DB_P   = 16'd4;

  logic       clk = 1'b0;
  logic       rst_btn, start_btn, cnt_done;
  logic [3:0] cnt_led;
  logic       go_n, busy, all_done, timeout_err;
  logic [7:0] run_count;

  run_sequencer #(.RUNS(RUNS_P), .TIMEOUT_CYCLES(TMO_P), .DEBOUNCE_CYCLES(DB_P)) dut (
    .clk(clk), .rst_btn(rst_btn), .start_btn(start_btn), .cnt_led(cnt_led),
    .cnt_done(cnt_done), .go_n(go_n), .busy(busy), .run_count(run_count),
    .all_done(all_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_press = 0;
  int t_err = 0;
  int done_pulses = 0;
  int ev_num = 0;
  int arm_times[$];
  logic [11:0] sb_q[$];
  logic [11:0] last_vec;
  logic [11:0] exp_vec;
  bit mon_en = 0;

  wire [11:0] out_vec = {go_n, busy, all_done, timeout_err, run_count};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] ev(input logic g, input logic b, input logic a,
                                     input logic t, input logic [7:0] rc);
    return {g, b, a, t, rc};
  endfunction

  // Monitor: one scoreboard pop per change of the output vector.
  always @(negedge clk) begin
    if (mon_en && (out_vec !== last_vec)) begin
      ev_num++;
      if (last_vec[11] && !go_n) arm_times.push_back(cyc);
      if (!last_vec[8] && timeout_err) t_err = cyc;
      if (all_done) done_pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event #%0d got=%h required=none", ev_num, out_vec);
      end else begin
        exp_vec = sb_q.pop_front();
        if (out_vec !== exp_vec) begin
          errors++;
          $display("FAIL event #%0d got=%h required=%h", ev_num, out_vec, exp_vec);
        end else begin
          $display("event #%0d cyc=%0d go_n=%0b busy=%0b all_done=%0b timeout_err=%0b run_count=%0d ok",
                   ev_num, cyc, go_n, busy, all_done, timeout_err, run_count);
        end
      end
      last_vec = out_vec;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic press(input int hold);
    start_btn = 1'b0;
    t_press = cyc;
    tick(hold);
    start_btn = 1'b1;
  endtask

  task automatic wait_go_low(output bit ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (go_n == 1'b0) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_go_low got=timeout required=go_n_low");
    end
  endtask

  // Counter model. mode 0: normal run; 1: leave done stuck high;
  // 2: stop once cnt_led has been raised.
  task automatic counter_run(input int mode, input int run_len);
    bit ok;
    wait_go_low(ok);
    if (ok) begin
      tick(20);
      cnt_led = 4'd1;
      if (mode != 2) begin
        tick(run_len);
        cnt_done = 1'b1;
        tick(30);
        if (mode != 1) cnt_done = 1'b0;
        cnt_led = 4'd0;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (sb_q.size() == 0) break;
      tick(1);
    end
    chk({name, "_pending_events"}, sb_q.size(), 0);
    sb_q.delete();
    tick(20);
  endtask

  task automatic push_full_launch();
    sb_q.push_back(ev(0, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(0, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd2));
    sb_q.push_back(ev(1, 0, 1, 0, 8'd2));
    sb_q.push_back(ev(1, 0, 0, 0, 8'd2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;
    rst_btn = 1'b0; start_btn = 1'b1; cnt_led = 4'd0; cnt_done = 1'b0;
    tick(3);
    rst_btn = 1'b1;
    tick(1);
    chk("reset_go_n", int'(go_n), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_run_count", int'(run_count), 0);
    chk("reset_all_done", int'(all_done), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    last_vec = ev(1, 0, 0, 0, 8'd0);
    mon_en = 1;

    // Normal two-run launch.
    push_full_launch();
    done_pulses = 0;
    arm_times.delete();
    fork
      press(10);
      begin
        counter_run(0, 10);
        counter_run(0, 10);
      end
    join
    drain("normal");
    chk("normal_all_done_pulses", done_pulses, 1);
    chk("normal_arm_entries", arm_times.size(), 2);
    chk("normal_start_latency", (arm_times.size() > 0) ? arm_times[0] - t_press : -1, 8);

    // Bounce rejection: nothing may be pushed, so any event fails.
    for (int i = 0; i < 10; i++) begin
      start_btn = ~start_btn;
      tick(2);
    end
    start_btn = 1'b1;
    tick(40);
    chk("bounce_go_n", int'(go_n), 1);
    chk("bounce_busy", int'(busy), 0);

    // Second press during RUN must be ignored.
    push_full_launch();
    done_pulses = 0;
    fork
      press(10);
      begin
        counter_run(0, 40);
        counter_run(0, 10);
      end
      begin
        wait_go_low(ok);
        tick(26);
        press(10);
      end
    join
    drain("ignored_press");
    chk("ignored_all_done_pulses", done_pulses, 1);
    chk("ignored_run_count", int'(run_count), 2);

    // Arm timeout, then a second press clears the error and relaunches.
    sb_q.push_back(ev(0, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 0, 0, 1, 8'd0));
    arm_times.delete();
    press(10);
    drain("arm_timeout");
    chk("arm_timeout_cycles", (arm_times.size() > 0) ? t_err - arm_times[0] : -1, 200);
    chk("arm_timeout_err", int'(timeout_err), 1);
    chk("arm_timeout_go_n", int'(go_n), 1);
    chk("arm_timeout_busy", int'(busy), 0);
    push_full_launch();
    fork
      press(10);
      begin
        counter_run(0, 10);
        counter_run(0, 10);
      end
    join
    drain("rearm");

    // Done stuck high after the first run: GAP times out with one run done.
    sb_q.push_back(ev(0, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(1, 0, 0, 1, 8'd1));
    fork
      press(10);
      counter_run(1, 10);
    join
    drain("done_stuck");
    chk("done_stuck_run_count", int'(run_count), 1);
    cnt_done = 1'b0;
    sb_q.push_back(ev(1, 0, 0, 0, 8'd0));
    rst_btn = 1'b0;
    tick(1);
    rst_btn = 1'b1;
    drain("err_reset");

    // Reset during the second run.
    sb_q.push_back(ev(0, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd0));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(0, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(1, 1, 0, 0, 8'd1));
    sb_q.push_back(ev(1, 0, 0, 0, 8'd0));
    fork
      press(10);
      begin
        counter_run(0, 10);
        counter_run(2, 10);
        tick(6);
        rst_btn = 1'b0;
        tick(1);
        rst_btn = 1'b1;
        chk("midreset_go_n", int'(go_n), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_run_count", int'(run_count), 0);
        chk("midreset_timeout_err", int'(timeout_err), 0);
        cnt_led = 4'd0;
      end
    join
    tick(30);
    chk("midreset_stays_idle_go_n", int'(go_n), 1);
    drain("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
